// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit: op encoding,
// per-stage control payload and the carry-in mapping used by stage 0.
package addsub_pkg;

    localparam logic OP_SUB = 1'b0;
    localparam logic OP_ADD = 1'b1;

    // Control part of the payload that travels with a beat. The operand and
    // result slices ride alongside in WIDTH-wide stage registers in the top.
    typedef struct packed {
        logic op;        // OP_SUB / OP_ADD
        logic carry;     // internal carry out of the chunk resolved here
        logic zero_acc;  // running AND of per-chunk zero detects
    } stage_ctrl_t;

    // Subtract runs as A + ~B + ~cin, so the borrow-in enters inverted.
    function automatic logic map_cin(input logic op, input logic cin);
        return (op == OP_ADD) ? cin : ~cin;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-wide adder slice. Besides sum and carry-out it reports
// whether the slice sum is zero and the carry into its MSB, which the top
// stage uses to detect signed overflow.
module addsub_chunk #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout,
    output logic             o_zero,
    output logic             o_cmsb
);

    logic [CHUNK:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
    assign o_sum  = w_full[CHUNK-1:0];
    assign o_cout = w_full[CHUNK];
    assign o_zero = (w_full[CHUNK-1:0] == '0);
    // Sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out for free.
    assign o_cmsb = w_full[CHUNK-1] ^ i_a[CHUNK-1] ^ i_b[CHUNK-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit: one CHUNK-wide slice resolves per stage with
// the carry registered between stages. A single global enable gives full
// backpressure; comparison flags are registered together with the result.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_cb,
    output logic             out_zero,
    output logic             out_ltu,
    output logic             out_lts,
    output logic             out_ovf
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_params
        $error("pipelined_addsub: WIDTH must be a multiple of CHUNK");
    end

    // Whole pipeline advances or holds as one; only a stalled output blocks it.
    logic w_en;
    assign w_en     = !(out_valid && !out_ready);
    assign in_ready = w_en;

    // Stage registers: entry k holds the beat after chunk k has resolved.
    logic             r_valid [STAGES];
    stage_ctrl_t      r_ctrl  [STAGES];
    logic [WIDTH-1:0] r_a     [STAGES];
    logic [WIDTH-1:0] r_b     [STAGES];
    logic [WIDTH-1:0] r_s     [STAGES];

    // Per-stage combinational results, exposed for the final flag logic.
    logic             w_op_src [STAGES];
    logic             w_cout   [STAGES];
    logic             w_cmsb   [STAGES];
    logic [WIDTH-1:0] w_s_next [STAGES];

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic [WIDTH-1:0] w_a_src;
        logic [WIDTH-1:0] w_b_src;
        logic [WIDTH-1:0] w_s_src;
        logic [WIDTH-1:0] w_s_merged;
        logic             w_valid_src;
        logic             w_c_src;
        logic             w_z_src;
        logic [CHUNK-1:0] w_b_chunk;
        logic [CHUNK-1:0] w_sum;
        logic             w_czero;

        if (gi == 0) begin : g_first
            assign w_valid_src  = in_valid;
            assign w_op_src[gi] = in_op;
            assign w_a_src      = in_a;
            assign w_b_src      = in_b;
            assign w_s_src      = '0;
            assign w_c_src      = map_cin(in_op, in_cin);
            assign w_z_src      = 1'b1;
        end else begin : g_next
            assign w_valid_src  = r_valid[gi-1];
            assign w_op_src[gi] = r_ctrl[gi-1].op;
            assign w_a_src      = r_a[gi-1];
            assign w_b_src      = r_b[gi-1];
            assign w_s_src      = r_s[gi-1];
            assign w_c_src      = r_ctrl[gi-1].carry;
            assign w_z_src      = r_ctrl[gi-1].zero_acc;
        end

        assign w_b_chunk = (w_op_src[gi] == OP_ADD) ? w_b_src[gi*CHUNK +: CHUNK]
                                                    : ~w_b_src[gi*CHUNK +: CHUNK];

        addsub_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .i_a    (w_a_src[gi*CHUNK +: CHUNK]),
            .i_b    (w_b_chunk),
            .i_cin  (w_c_src),
            .o_sum  (w_sum),
            .o_cout (w_cout[gi]),
            .o_zero (w_czero),
            .o_cmsb (w_cmsb[gi])
        );

        // Splice this stage's chunk into the partially built result.
        always_comb begin
            w_s_merged                     = w_s_src;
            w_s_merged[gi*CHUNK +: CHUNK]  = w_sum;
        end
        assign w_s_next[gi] = w_s_merged;

        // Stage register: loads the advancing beat (or bubble) when enabled.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid[gi] <= 1'b0;
                r_ctrl[gi]  <= '0;
                r_a[gi]     <= '0;
                r_b[gi]     <= '0;
                r_s[gi]     <= '0;
            end else if (w_en) begin
                r_valid[gi]         <= w_valid_src;
                r_ctrl[gi].op       <= w_op_src[gi];
                r_ctrl[gi].carry    <= w_cout[gi];
                r_ctrl[gi].zero_acc <= w_z_src & w_czero;
                r_a[gi]             <= w_a_src;
                r_b[gi]             <= w_b_src;
                r_s[gi]             <= w_s_merged;
            end
        end
    end

    // Flags are decoded from the top chunk as it resolves, then registered
    // so they leave together with out_s and read 0 out of reset.
    logic w_last_v;
    logic w_last_n;
    logic w_last_sub;
    logic r_cb;
    logic r_ltu;
    logic r_lts;
    logic r_ovf;

    assign w_last_v   = w_cmsb[LAST] ^ w_cout[LAST];
    assign w_last_n   = w_s_next[LAST][WIDTH-1];
    assign w_last_sub = (w_op_src[LAST] == OP_SUB);

    // Final flag register, advancing in lockstep with the last stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cb  <= 1'b0;
            r_ltu <= 1'b0;
            r_lts <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_en) begin
            r_cb  <= w_last_sub ? ~w_cout[LAST] : w_cout[LAST];
            r_ltu <= w_last_sub & ~w_cout[LAST];
            r_lts <= w_last_sub & (w_last_n ^ w_last_v);
            r_ovf <= w_last_v;
        end
    end

    assign out_valid = r_valid[LAST];
    assign out_s     = r_s[LAST];
    assign out_zero  = r_ctrl[LAST].zero_acc;
    assign out_cb    = r_cb;
    assign out_ltu   = r_ltu;
    assign out_lts   = r_lts;
    assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed vectors, backpressure, mid-stream
// reset and two parameter variants, all checked against a scoreboard.
module tb_pipelined_addsub;

    typedef struct packed {
        logic [63:0] s;
        logic [4:0]  fl;       // {cb, zero, ltu, lts, ovf}
        logic        chk_lat;
        logic [31:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- main DUT, 64/16 ----------------
    logic        in_valid = 1'b0, in_op = 1'b0, in_cin = 1'b0, out_ready = 1'b1;
    logic [63:0] in_a = '0, in_b = '0;
    logic        in_ready, out_valid, out_cb, out_zero, out_ltu, out_lts, out_ovf;
    logic [63:0] out_s;
    logic [4:0]  fl;
    assign fl = {out_cb, out_zero, out_ltu, out_lts, out_ovf};

    pipelined_addsub #(.WIDTH(64), .CHUNK(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
        .out_cb(out_cb), .out_zero(out_zero), .out_ltu(out_ltu),
        .out_lts(out_lts), .out_ovf(out_ovf)
    );

    // ---------------- variant 32/8 ----------------
    logic        x_valid = 1'b0, x_op = 1'b0, x_cin = 1'b0, x_oready = 1'b1;
    logic [31:0] x_a = '0, x_b = '0, x_s;
    logic        x_ready, x_ovalid, x_cb, x_zero, x_ltu, x_lts, x_ovf;

    pipelined_addsub #(.WIDTH(32), .CHUNK(8)) dut32 (
        .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(x_ready),
        .in_op(x_op), .in_a(x_a), .in_b(x_b), .in_cin(x_cin),
        .out_valid(x_ovalid), .out_ready(x_oready), .out_s(x_s),
        .out_cb(x_cb), .out_zero(x_zero), .out_ltu(x_ltu),
        .out_lts(x_lts), .out_ovf(x_ovf)
    );

    // ---------------- variant 48/48 (single stage) ----------------
    logic        y_valid = 1'b0, y_op = 1'b0, y_cin = 1'b0, y_oready = 1'b1;
    logic [47:0] y_a = '0, y_b = '0, y_s;
    logic        y_ready, y_ovalid, y_cb, y_zero, y_ltu, y_lts, y_ovf;

    pipelined_addsub #(.WIDTH(48), .CHUNK(48)) dut48 (
        .clk(clk), .rst(rst), .in_valid(y_valid), .in_ready(y_ready),
        .in_op(y_op), .in_a(y_a), .in_b(y_b), .in_cin(y_cin),
        .out_valid(y_ovalid), .out_ready(y_oready), .out_s(y_s),
        .out_cb(y_cb), .out_zero(y_zero), .out_ltu(y_ltu),
        .out_lts(y_lts), .out_ovf(y_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: arithmetic on widened integers, signed compare on sign-extended values.
    function automatic exp_t model(input int w, input logic op, input logic [63:0] a,
                                   input logic [63:0] b, input logic cin);
        exp_t        e;
        logic [64:0] mask, ea, eb, full;
        logic [66:0] m67, sa, sb, sbc;
        logic        cb, zero, ltu, lts, ovf, am, bm, sm;
        mask = (65'd1 << w) - 65'd1;
        ea   = {1'b0, a} & mask;
        eb   = {1'b0, b} & mask;
        if (op) full = ea + eb + {64'd0, cin};
        else    full = ea - eb - {64'd0, cin};
        e.s  = full[63:0] & mask[63:0];
        if (op) cb = full[w];
        else    cb = (ea < eb + {64'd0, cin});
        am   = ea[w-1];
        bm   = eb[w-1];
        sm   = e.s[w-1];
        ovf  = op ? ((am == bm) && (sm != am)) : ((am != bm) && (sm != am));
        m67  = (67'd1 << w) - 67'd1;
        sa   = {2'b00, ea};
        sb   = {2'b00, eb};
        if (am) sa = sa | ~m67;
        if (bm) sb = sb | ~m67;
        sbc  = sb + {66'd0, cin};
        lts  = op ? 1'b0 : ($signed(sa) < $signed(sbc));
        ltu  = op ? 1'b0 : cb;
        zero = (e.s == 64'd0);
        e.fl = {cb, zero, ltu, lts, ovf};
        e.chk_lat = 1'b0;
        e.cyc = '0;
        return e;
    endfunction

    // Main scoreboard + handshake/stability monitor, sampled on the falling edge.
    exp_t        q_main[$];
    logic        lat_mode = 1'b1;
    int          n_out = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_s = '0;
    logic [4:0]  prev_fl = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            chk("in_ready_rule", {63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)});
            if (prev_stall) begin
                chk("stall_valid", {63'd0, out_valid}, 64'd1);
                chk("stall_s", out_s, prev_s);
                chk("stall_flags", {59'd0, fl}, {59'd0, prev_fl});
            end
            if (in_valid && in_ready) begin
                e = model(64, in_op, in_a, in_b, in_cin);
                e.chk_lat = lat_mode;
                e.cyc = cyc;
                q_main.push_back(e);
            end
            if (out_valid && out_ready) begin
                n_out++;
                chk("sb_nonempty", {63'd0, q_main.size() != 0}, 64'd1);
                if (q_main.size() != 0) begin
                    e = q_main.pop_front();
                    $display("[TB] main out s=0x%016h flags=%05b", out_s, fl);
                    chk("sb_s", out_s, e.s);
                    chk("sb_flags", {59'd0, fl}, {59'd0, e.fl});
                    if (e.chk_lat) chk("sb_latency", {32'd0, cyc - e.cyc}, 64'd4);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_s     = out_s;
            prev_fl    = fl;
        end
    end

    // Variant scoreboards: always-ready sink, so latency must equal STAGES.
    exp_t q32[$];
    exp_t q48[$];
    int   n32 = 0, n48 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (x_valid && x_ready) begin
                e = model(32, x_op, {32'd0, x_a}, {32'd0, x_b}, x_cin);
                e.cyc = cyc;
                q32.push_back(e);
            end
            if (x_ovalid) begin
                n32++;
                chk("w32_nonempty", {63'd0, q32.size() != 0}, 64'd1);
                if (q32.size() != 0) begin
                    e = q32.pop_front();
                    chk("w32_s", {32'd0, x_s}, e.s);
                    chk("w32_flags", {59'd0, x_cb, x_zero, x_ltu, x_lts, x_ovf}, {59'd0, e.fl});
                    chk("w32_latency", {32'd0, cyc - e.cyc}, 64'd4);
                end
            end
            if (y_valid && y_ready) begin
                e = model(48, y_op, {16'd0, y_a}, {16'd0, y_b}, y_cin);
                e.cyc = cyc;
                q48.push_back(e);
            end
            if (y_ovalid) begin
                n48++;
                chk("w48_nonempty", {63'd0, q48.size() != 0}, 64'd1);
                if (q48.size() != 0) begin
                    e = q48.pop_front();
                    chk("w48_s", {16'd0, y_s}, e.s);
                    chk("w48_flags", {59'd0, y_cb, y_zero, y_ltu, y_lts, y_ovf}, {59'd0, e.fl});
                    chk("w48_latency", {32'd0, cyc - e.cyc}, 64'd1);
                end
            end
        end
    end

    logic       bp_mode = 1'b0;
    logic [3:0] bp_pat  = 4'b1001;   // out_ready sequence 1,0,0,1 (bit 0 first)
    int         bp_idx  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_mode) begin
            out_ready = bp_pat[bp_idx % 4];
            bp_idx++;
        end
    endtask

    task automatic send(input logic op, input logic [63:0] a, input logic [63:0] b,
                        input logic cin);
        logic acc;
        int   guard;
        guard    = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        do begin
            @(negedge clk);
            acc = in_ready;
            tick();
            guard++;
        end while (!acc && guard < 200);
        if (!acc) chk("send_timeout", {63'd0, acc}, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic run_dir(input string tag, input logic op, input logic [63:0] a,
                           input logic [63:0] b, input logic cin,
                           input logic [63:0] es, input logic [4:0] efl);
        int k;
        send(op, a, b, cin);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 20);
        $display("[TB] %s: lat=%0d s=0x%016h flags=%05b", tag, k, out_s, fl);
        chk({tag, "_lat"}, 64'(k), 64'd4);
        chk({tag, "_s"}, out_s, es);
        chk({tag, "_flags"}, {59'd0, fl}, {59'd0, efl});
        tick();
    endtask

    initial begin
        int base, seen, guard;

        // Reset state
        repeat (2) tick();
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_s", out_s, 64'd0);
        chk("rst_flags", {59'd0, fl}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        rst = 1'b0;
        tick();

        // Directed vectors, flags = {cb, zero, ltu, lts, ovf}
        run_dir("sub_ripple", 1'b0, 64'h0000_0001_0000_0000, 64'd1, 1'b0,
                64'h0000_0000_FFFF_FFFF, 5'b00000);
        run_dir("sub_neg", 1'b0, 64'd5, 64'd7, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFE, 5'b10110);
        run_dir("sub_eq", 1'b0, 64'h1234, 64'h1234, 1'b0, 64'd0, 5'b01000);
        run_dir("add_ovf", 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                64'h8000_0000_0000_0000, 5'b00001);
        run_dir("add_wrap", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 5'b11000);
        run_dir("sub_min_bin", 1'b0, 64'h8000_0000_0000_0000, 64'd0, 1'b1,
                64'h7FFF_FFFF_FFFF_FFFF, 5'b00011);

        // Backpressure: 8 back-to-back beats with out_ready cycling 1,0,0,1
        lat_mode = 1'b0;
        base     = n_out;
        bp_idx   = 0;
        bp_mode  = 1'b1;
        for (int i = 0; i < 8; i++)
            send(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                 1'($urandom_range(0, 1)));
        guard = 0;
        while (q_main.size() != 0 && guard < 100) begin
            tick();
            guard++;
        end
        bp_mode   = 1'b0;
        out_ready = 1'b1;
        $display("[TB] backpressure: %0d beats out", n_out - base);
        chk("bp_count", 64'(n_out - base), 64'd8);
        chk("bp_drained", 64'(q_main.size()), 64'd0);
        tick();

        // Reset with 3 beats in flight, the oldest stalled at the output
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b1, 64'(i + 100), 64'd1, 1'b0);
        tick();
        chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        #2 rst = 1'b1;
        #1;
        q_main.delete();
        $display("[TB] reset mid-stream: out_valid=%0b in_ready=%0b", out_valid, in_ready);
        chk("midrst_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_s", out_s, 64'd0);
        chk("midrst_flags", {59'd0, fl}, 64'd0);
        chk("midrst_ready", {63'd0, in_ready}, 64'd1);
        q32.delete();
        q48.delete();
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        seen      = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rst_no_ghost", 64'(seen), 64'd0);
        tick();
        lat_mode = 1'b1;
        run_dir("post_rst", 1'b0, 64'd10, 64'd3, 1'b0, 64'd7, 5'b00000);

        // Parameter variants with random operands, ops and carry-in
        for (int i = 0; i < 24; i++) begin
            x_valid = 1'b1;
            x_op    = 1'($urandom_range(0, 1));
            x_cin   = 1'($urandom_range(0, 1));
            x_a     = (i == 0) ? 32'h8000_0000 : $urandom;
            x_b     = (i == 0) ? 32'h0000_0001 : ((i == 1) ? x_a : $urandom);
            y_valid = 1'b1;
            y_op    = 1'($urandom_range(0, 1));
            y_cin   = 1'($urandom_range(0, 1));
            y_a     = {$urandom, $urandom};
            y_b     = (i == 2) ? y_a : 48'({$urandom, $urandom});
            tick();
        end
        x_valid = 1'b0;
        y_valid = 1'b0;
        repeat (8) tick();
        $display("[TB] sweep: w32 outputs=%0d w48 outputs=%0d", n32, n48);
        chk("w32_count", 64'(n32), 64'd24);
        chk("w48_count", 64'(n48), 64'd24);
        chk("w32_drained", 64'(q32.size()), 64'd0);
        chk("w48_drained", 64'(q48.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
